// File: rtl/step_sequencer_if.sv
// step_sequencer_if: pattern/control inputs and playback outputs of step_sequencer
// master drives note1..note4, start, stop, clear, tempo_sel; slave drives step, trig, gate,
// step_wrap, running, audio_out
interface step_sequencer_if;
  logic [15:0] note1, note2, note3, note4;
  logic start, stop, clear;
  logic [1:0] tempo_sel;
  logic [3:0] step, trig, gate;
  logic step_wrap, running, audio_out;
  modport master (
    output note1, note2, note3, note4, start, stop, clear, tempo_sel,
    input step, trig, gate, step_wrap, running, audio_out
  );
  modport slave (
    input note1, note2, note3, note4, start, stop, clear, tempo_sel,
    output step, trig, gate, step_wrap, running, audio_out
  );
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: 16-step playback of four track patterns with trigger, gate and square-wave tone
// clk/resetn (sync, active-low); sif.slave: note1..note4, start/stop/clear pulses, tempo_sel in;
// step, trig, gate, step_wrap, running, audio_out out (all registered)
module step_sequencer #(
  parameter int unsigned STEP_CYCLES = 6_250_000,
  parameter int unsigned GATE_CYCLES = 3_125_000,
  parameter int unsigned TONE0_HALF = 47_801,
  parameter int unsigned TONE1_HALF = 37_936,
  parameter int unsigned TONE2_HALF = 31_888,
  parameter int unsigned TONE3_HALF = 23_900
) (
  input logic clk,
  input logic resetn,
  step_sequencer_if.slave sif
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] tick, period, reload;
  logic [31:0] gcnt [4];
  logic [31:0] gcnt_n [4];
  logic [31:0] tcnt [4];
  logic [31:0] tcnt_n [4];
  logic [3:0] step, trig, gate, tone, trig_n, gate_n, tone_n;
  logic step_wrap, running, audio, audio_n, run_n, enter, stay, wrap;
  function automatic logic [31:0] half(input int k);
    return k == 0 ? TONE0_HALF : k == 1 ? TONE1_HALF : k == 2 ? TONE2_HALF : TONE3_HALF;
  endfunction
  assign sif.step = step;
  assign sif.trig = trig;
  assign sif.gate = gate;
  assign sif.step_wrap = step_wrap;
  assign sif.running = running;
  assign sif.audio_out = audio;
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = sif.clear ? IDLE : sif.stop ? (state == RUN ? HOLD : state) : sif.start ? RUN : state;
    run_n = state_n == RUN;
    enter = run_n && state != RUN;
    stay = run_n && state == RUN;
    wrap = stay && tick == period - 32'd1;
    reload = STEP_CYCLES >> sif.tempo_sel;
    // patterns are sampled live at the first tick of each step
    trig_n = (stay && tick == 32'd0) ?
             {sif.note4[step], sif.note3[step], sif.note2[step], sif.note1[step]} : 4'b0;
    // leaving RUN clears gates and tones at the same edge; a tone restarts phase-low whenever its gate is low
    for (int k = 0; k < 4; k++) begin
      gcnt_n[k] = !run_n ? 32'd0 : trig[k] ? GATE_CYCLES : gcnt[k] != 32'd0 ? gcnt[k] - 32'd1 : 32'd0;
      gate_n[k] = gcnt_n[k] != 32'd0;
      tcnt_n[k] = (run_n && gate[k] && tcnt[k] != half(k) - 32'd1) ? tcnt[k] + 32'd1 : 32'd0;
      tone_n[k] = run_n && gate[k] && (tcnt[k] == half(k) - 32'd1 ? !tone[k] : tone[k]);
    end
    audio_n = |(gate_n & tone_n);
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      step <= 4'd0;
      tick <= 32'd0;
      period <= STEP_CYCLES;
      trig <= 4'd0;
      gate <= 4'd0;
      tone <= 4'd0;
      step_wrap <= 1'b0;
      running <= 1'b0;
      audio <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        gcnt[k] <= 32'd0;
        tcnt[k] <= 32'd0;
      end
    end else begin
      running <= run_n;
      trig <= trig_n;
      gate <= gate_n;
      tone <= tone_n;
      audio <= audio_n;
      step_wrap <= wrap && step == 4'd15;
      gcnt <= gcnt_n;
      tcnt <= tcnt_n;
      // period only changes on step boundaries so a tempo change never reshapes the current step
      if (sif.clear) begin
        step <= 4'd0;
        tick <= 32'd0;
      end else if (enter) begin
        tick <= 32'd0;
        period <= reload;
        if (state == IDLE) step <= 4'd0;
      end else if (wrap) begin
        tick <= 32'd0;
        step <= step + 4'd1;
        period <= reload;
      end else if (stay) tick <= tick + 32'd1;
    end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: scoreboard bench for step_sequencer with directed vectors
module tb_step_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int c;
    logic [3:0] s;
    logic [3:0] t;
  } exp_t;
  exp_t q[$];
  step_sequencer_if sif();
  step_sequencer #(
    .STEP_CYCLES(16), .GATE_CYCLES(2),
    .TONE0_HALF(1), .TONE1_HALF(2), .TONE2_HALF(3), .TONE3_HALF(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .sif(sif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic go_to(input int c);
    if (c > cyc) adv(c - cyc);
  endtask
  task automatic push(input int c, input logic [3:0] s, input logic [3:0] t);
    exp_t e;
    e.c = c;
    e.s = s;
    e.t = t;
    q.push_back(e);
  endtask
  task automatic pulse_start;
    sif.start = 1'b1;
    adv(1);
    sif.start = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sif.trig != 4'd0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_trig got=%0h step=%0d want=none cycle=%0d", sif.trig, sif.step, cyc);
      end else begin
        e = q.pop_front();
        chk("trig_cycle", cyc, e.c);
        chk("trig_step", sif.step, e.s);
        chk("trig_val", sif.trig, e.t);
      end
    end
  end
  initial begin
    int a, b, s, h, t, r, wraps, wrap_at, wrap_step, viol, aud;
    sif.note1 = 16'h0; sif.note2 = 16'h0; sif.note3 = 16'h0; sif.note4 = 16'h0;
    sif.start = 1'b0; sif.stop = 1'b0; sif.clear = 1'b0; sif.tempo_sel = 2'd0;
    adv(2);
    chk("rst_step", sif.step, 0);
    chk("rst_trig", sif.trig, 0);
    chk("rst_gate", sif.gate, 0);
    chk("rst_running", sif.running, 0);
    chk("rst_audio", sif.audio_out, 0);
    chk("rst_wrap", sif.step_wrap, 0);
    // single note on track 0
    sif.note1 = 16'h0001;
    resetn = 1'b1;
    a = cyc;
    push(a + 2, 4'd0, 4'b0001);
    pulse_start();
    chk("t1_running", sif.running, 1);
    go_to(a + 2); chk("t1_gate_c2", sif.gate, 0);
    go_to(a + 3); chk("t1_gate_c3", sif.gate, 4'b0001); chk("t1_aud_c3", sif.audio_out, 0);
    go_to(a + 4); chk("t1_gate_c4", sif.gate, 4'b0001); chk("t1_aud_c4", sif.audio_out, 1);
    go_to(a + 5); chk("t1_gate_c5", sif.gate, 0); chk("t1_aud_c5", sif.audio_out, 0);
    go_to(a + 16); chk("t1_step_c16", sif.step, 0);
    go_to(a + 17); chk("t1_step_c17", sif.step, 1);
    // all tracks on, full cycle
    sif.clear = 1'b1;
    adv(1);
    sif.clear = 1'b0;
    chk("clr_running", sif.running, 0);
    chk("clr_step", sif.step, 0);
    sif.note1 = 16'hFFFF; sif.note2 = 16'hFFFF; sif.note3 = 16'hFFFF; sif.note4 = 16'hFFFF;
    b = cyc;
    for (int k = 0; k <= 16; k++) push(b + 2 + 16 * k, 4'(k), 4'hF);
    pulse_start();
    wraps = 0; wrap_at = 0; wrap_step = 99; viol = 0; aud = 0;
    for (int i = 0; i < 257; i++) begin
      if (sif.step_wrap) begin
        wraps++;
        wrap_at = cyc - b;
        wrap_step = int'(sif.step);
      end
      if (sif.audio_out && sif.gate == 4'd0) viol++;
      if (sif.audio_out) aud++;
      adv(1);
    end
    chk("t2_wraps", wraps, 1);
    chk("t2_wrap_at", wrap_at, 257);
    chk("t2_wrap_step", wrap_step, 0);
    chk("t2_aud_no_gate", viol, 0);
    chk("t2_aud_seen", aud != 0, 1);
    // stop during step 5, then resume
    s = b + 256;
    for (int k = 1; k <= 5; k++) push(s + 2 + 16 * k, 4'(k), 4'hF);
    go_to(s + 83);
    chk("t3_gate_before", sif.gate, 4'hF);
    sif.stop = 1'b1;
    adv(1);
    sif.stop = 1'b0;
    chk("t3_gate_off", sif.gate, 0);
    chk("t3_aud_off", sif.audio_out, 0);
    chk("t3_running", sif.running, 0);
    chk("t3_step", sif.step, 5);
    adv(5);
    chk("t3_step_hold", sif.step, 5);
    h = cyc;
    push(h + 2, 4'd5, 4'hF);
    pulse_start();
    chk("t3_resume", sif.running, 1);
    // clear wins over start
    go_to(h + 3);
    chk("t4_gate_before", sif.gate, 4'hF);
    sif.clear = 1'b1;
    sif.start = 1'b1;
    adv(1);
    sif.clear = 1'b0;
    sif.start = 1'b0;
    chk("t4_running", sif.running, 0);
    chk("t4_step", sif.step, 0);
    chk("t4_gate", sif.gate, 0);
    go_to(h + 40);
    chk("t4_idle", sif.running, 0);
    // tempo change mid-step
    t = cyc;
    push(t + 2, 4'd0, 4'hF);
    push(t + 18, 4'd1, 4'hF);
    push(t + 22, 4'd2, 4'hF);
    push(t + 26, 4'd3, 4'hF);
    pulse_start();
    go_to(t + 4);
    sif.tempo_sel = 2'd2;
    go_to(t + 16); chk("t5_step_c16", sif.step, 0);
    go_to(t + 17); chk("t5_step_c17", sif.step, 1);
    go_to(t + 20); chk("t5_step_c20", sif.step, 1);
    go_to(t + 21); chk("t5_step_c21", sif.step, 2);
    go_to(t + 25); chk("t5_step_c25", sif.step, 3);
    // reset mid-gate
    go_to(t + 27);
    chk("t6_gate_before", sif.gate, 4'hF);
    resetn = 1'b0;
    adv(1);
    resetn = 1'b1;
    sif.tempo_sel = 2'd0;
    chk("t6_step", sif.step, 0);
    chk("t6_trig", sif.trig, 0);
    chk("t6_gate", sif.gate, 0);
    chk("t6_running", sif.running, 0);
    chk("t6_audio", sif.audio_out, 0);
    chk("t6_wrap", sif.step_wrap, 0);
    go_to(t + 38);
    chk("t6_stays_idle", sif.running, 0);
    r = cyc;
    push(r + 2, 4'd0, 4'hF);
    pulse_start();
    chk("t6_resume", sif.running, 1);
    go_to(r + 3); chk("t6_gate_resume", sif.gate, 4'hF);
    go_to(r + 8);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
